// File: rtl/w25q_pkg.sv
// Shared definitions for the W25Q read streamer: FSM encoding, address step and buffer sizing.
// byte_swap32 backs the optional W25Q_STREAM_BYTESWAP_EN build of the streamer.
package w25q_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ADDR_STEP          = 4;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/w25q_word_fifo.sv
// Synchronous word FIFO with async reset; a push into a full FIFO is taken only alongside a pop.
// rdata reads as zero while empty so downstream data is clean between bursts.
module w25q_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/w25q_read_streamer.sv
// Streams a burst of 32-bit flash words through a single-word SPI reader into a word FIFO.
// Optional build macro: W25Q_STREAM_BYTESWAP_EN byte-reverses each word before buffering.
module w25q_read_streamer
    import w25q_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_start,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_words,
    output logic              req_ready,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_busy,
    input  logic [31:0]       rd_data,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [15:0]       remain_q, remain_nx;
    logic              pending_q, pending_nx;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [32:0]       fifo_rdata;
    logic [31:0]       word_in;
    logic              space_after_push;

`ifdef W25Q_STREAM_BYTESWAP_EN
    assign word_in = byte_swap32(rd_data);
`else
    assign word_in = rd_data;
`endif

    assign req_ready = (state == IDLE) && !rd_busy;
    assign rd_start  = (state == ISSUE);
    assign rd_addr   = addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[31:0];
    assign out_last  = fifo_rdata[32];
    assign fifo_pop  = out_valid && out_ready;

    // Occupancy after this cycle's capture still leaves room for one more word.
    assign space_after_push = fifo_pop || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            remain_q  <= remain_nx;
            pending_q <= pending_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        remain_nx  = remain_q;
        pending_nx = pending_q;
        fifo_push  = 1'b0;
        case (state)
            IDLE: begin
                if (req_start && req_ready && (req_words != 16'd0) && !fifo_full) begin
                    addr_nx   = req_addr;
                    remain_nx = req_words;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_busy) begin
                    pending_nx = 1'b1;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                // pending_q low means the word is already captured and we are stalled on a full FIFO.
                if (pending_q) begin
                    if (!rd_busy) begin
                        fifo_push  = 1'b1;
                        pending_nx = 1'b0;
                        addr_nx    = addr_q + ADDR_W'(ADDR_STEP);
                        remain_nx  = remain_q - 16'd1;
                        if (remain_q == 16'd1)     state_nx = DONE;
                        else if (space_after_push) state_nx = ISSUE;
                    end
                end else if (!fifo_full) begin
                    state_nx = ISSUE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    w25q_word_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({remain_q == 16'd1, word_in}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_w25q_read_streamer.sv
// Bench for w25q_read_streamer: reader model, burst-level scoreboard, vector table and corner sequences.
// Expected words come from the burst definition (address walk, per-address data, last flag on final word).
module tb_w25q_read_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_start;
    logic [23:0] req_addr;
    logic [15:0] req_words;
    logic        req_ready;
    logic        rd_start;
    logic [23:0] rd_addr;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    always #5 clk = ~clk;

    w25q_read_streamer #(.FIFO_DEPTH(4), .ADDR_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_start (req_start),
        .req_addr  (req_addr),
        .req_words (req_words),
        .req_ready (req_ready),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

`ifdef W25Q_STREAM_BYTESWAP_EN
    localparam logic [31:0] SWAP_EXP = 32'h44332211;
`else
    localparam logic [31:0] SWAP_EXP = 32'h11223344;
`endif

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_addr_q[$];
    logic [32:0] exp_out_q[$];

    int          reads = 0;
    int          n_out = 0;
    logic [23:0] last_rd_addr = '0;
    logic [31:0] last_out_data = '0;
    logic        last_out_last = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    int          lat_cfg = 0;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    function automatic logic [31:0] src_data(input logic [23:0] a);
        if (ovr_en) return ovr_data;
        return {a[15:0] ^ 16'hA5C3, a[23:16] + 8'h17, a[7:0] ^ 8'h3C};
    endfunction

    function automatic logic [31:0] apply_cfg(input logic [31:0] d);
`ifdef W25Q_STREAM_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Flash reader model: accepts rd_start when idle, stays busy for a few cycles, then presents data.
    initial begin
        int          busy_left;
        logic [31:0] cur_data;
        busy_left = 0;
        cur_data  = '0;
        rd_busy   = 1'b0;
        rd_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    rd_busy = 1'b0;
                    rd_data = cur_data;
                end
            end else if (rd_start) begin
                reads++;
                last_rd_addr = rd_addr;
                if (exp_addr_q.size() == 0) fail_now("unexpected_rd_start");
                else check("rd_addr", rd_addr, exp_addr_q.pop_front());
                cur_data  = src_data(rd_addr);
                rd_busy   = 1'b1;
                busy_left = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard on handshakes, stability while stalled.
    initial begin
        bit          prev_stall;
        logic [32:0] prev_word;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && out_valid) check("out_stable", {out_last, out_data}, prev_word);
            if (out_valid && out_ready) begin
                n_out++;
                last_out_data = out_data;
                last_out_last = out_last;
                if (exp_out_q.size() == 0) fail_now("unexpected_out_word");
                else begin
                    e = exp_out_q.pop_front();
                    check("out_word", {out_last, out_data}, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic start_burst(input logic [23:0] a, input logic [15:0] w);
        bit          ok;
        logic [23:0] pa;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("start_wait");
        for (int i = 0; i < int'(w); i++) begin
            pa = a + 24'(4 * i);
            exp_addr_q.push_back(pa);
            exp_out_q.push_back({(i == int'(w) - 1), apply_cfg(src_data(pa))});
        end
        req_addr  = a;
        req_words = w;
        req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
        check("start_latency", rd_start, (w != 16'd0));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_out_q.size() == 0 && exp_addr_q.size() == 0 && req_ready) return;
        end
        fail_now("burst_done");
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [15:0] words;
        bit          ovr;
        logic [31:0] ovr_d;
        logic [23:0] exp_last_addr;
        bit          chk_data;
        logic [31:0] exp_last_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0;
        int o0;
        bit ok;

        vecs[0] = '{24'h010000, 16'd1, 1'b1, 32'hFFFFFFFF, 24'h010000, 1'b1, 32'hFFFFFFFF};
        vecs[1] = '{24'hFFFFF8, 16'd3, 1'b0, 32'h0,        24'h000000, 1'b0, 32'h0};
        vecs[2] = '{24'h000100, 16'd5, 1'b0, 32'h0,        24'h000110, 1'b0, 32'h0};
        vecs[3] = '{24'h010000, 16'd1, 1'b1, 32'h11223344, 24'h010000, 1'b1, SWAP_EXP};
        vecs[4] = '{24'hFFFFFC, 16'd2, 1'b0, 32'h0,        24'h000000, 1'b0, 32'h0};
        vecs[5] = '{24'h7FFFF0, 16'd4, 1'b1, 32'hA5A5A5A5, 24'h7FFFFC, 1'b1, 32'hA5A5A5A5};

        rst       = 1'b1;
        req_start = 1'b0;
        req_addr  = '0;
        req_words = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_start", rd_start, 1'b0);
        check("rst_rd_addr", rd_addr, 24'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_req_ready", req_ready, 1'b1);
        rst = 1'b0;

        rdy_mode = 0;
        foreach (vecs[v]) begin
            ovr_en   = vecs[v].ovr;
            ovr_data = vecs[v].ovr_d;
            n0 = reads;
            o0 = n_out;
            start_burst(vecs[v].addr, vecs[v].words);
            wait_done(300);
            check("vec_reads", reads - n0, int'(vecs[v].words));
            check("vec_outs", n_out - o0, int'(vecs[v].words));
            check("vec_last_addr", last_rd_addr, vecs[v].exp_last_addr);
            if (vecs[v].chk_data) begin
                check("vec_last_data", last_out_data, vecs[v].exp_last_data);
                check("vec_last_flag", last_out_last, 1'b1);
            end
        end
        ovr_en = 1'b0;

        // Backpressure: four reads fill the buffer, then the reader must stay idle.
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        n0 = reads;
        o0 = n_out;
        start_burst(24'h010000, 16'd6);
        repeat (80) @(negedge clk);
        check("bp_reads_stalled", reads - n0, 4);
        repeat (10) begin
            @(negedge clk);
            check("bp_rd_start_low", rd_start, 1'b0);
        end
        check("bp_out_valid", out_valid, 1'b1);
        rdy_mode = 0;
        wait_done(300);
        check("bp_reads_total", reads - n0, 6);
        check("bp_outs_total", n_out - o0, 6);
        check("bp_last_addr", last_rd_addr, 24'h010014);
        check("bp_last_flag", last_out_last, 1'b1);

        // Zero-length request is ignored.
        n0 = reads;
        start_burst(24'h010000, 16'd0);
        repeat (10) begin
            @(negedge clk);
            check("zero_req_ready", req_ready, 1'b1);
            check("zero_out_valid", out_valid, 1'b0);
        end
        check("zero_reads", reads - n0, 0);

        // Reset while a read is in flight.
        lat_cfg = 12;
        n0 = reads;
        start_burst(24'h020000, 16'd2);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (reads == n0 + 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("rst_wait_read");
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("midrst_rd_start", rd_start, 1'b0);
        check("midrst_rd_addr", rd_addr, 24'h0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_req_ready", req_ready, 1'b0);
        exp_addr_q.delete();
        exp_out_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!rd_busy) begin
                ok = 1'b1;
                break;
            end
            check("midrst_ready_held", req_ready, 1'b0);
        end
        if (!ok) fail_now("midrst_busy_release");
        check("midrst_ready_after", req_ready, 1'b1);
        o0 = n_out;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_word", out_valid, 1'b0);
        end
        check("midrst_outs", n_out - o0, 0);
        check("midrst_reads", reads - n0, 1);
        lat_cfg = 0;

        // Randomized bursts with random backpressure and reader latency.
        rdy_mode = 2;
        for (int t = 0; t < 15; t++) begin
            logic [23:0] a;
            logic [15:0] w;
            a = ($urandom_range(0, 2) == 0) ? 24'hFFFFE0 + 24'($urandom_range(0, 31))
                                           : 24'($urandom);
            a = a & 24'hFFFFFC;
            w = 16'($urandom_range(1, 9));
            n0 = reads;
            o0 = n_out;
            start_burst(a, w);
            wait_done(600);
            check("rand_reads", reads - n0, int'(w));
            check("rand_outs", n_out - o0, int'(w));
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/w25q_read_streamer.md
W25Q_READ_STREAMER -- requirements
Module: w25q_read_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the output word buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 24, meaning the flash byte-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port req_start, input, 1, a one-cycle pulse that starts a burst.
REQ-006 SHALL have port req_addr, input, ADDR_W, the burst base byte address.
REQ-007 SHALL have port req_words, input, 16, the number of 32-bit words to read.
REQ-008 SHALL have port req_ready, output, 1, which is high when the block is idle and can accept req_start.
REQ-009 SHALL have ports rd_start (output, 1), rd_addr (output, ADDR_W), rd_busy (input, 1) and rd_data (input, 32), connecting to the single-word SPI reader start/mem_addr/busy/mem_data.
REQ-010 SHALL have ports out_data (output, 32), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1), forming the output word stream.

Function
REQ-011 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-012 SHALL drive req_ready = (state==IDLE) && !rd_busy.
REQ-013 SHALL, in IDLE, on req_start && req_ready && req_words!=0, latch the address and word count and go to ISSUE; it SHALL ignore req_start when req_words==0 or when req_ready is low.
REQ-014 SHALL enter ISSUE only when the FIFO count is below FIFO_DEPTH; otherwise it SHALL stall in the previous state with rd_start low.
REQ-015 SHALL, in ISSUE, hold rd_start high and rd_addr stable until rd_busy is sampled high, then drop rd_start and go to WAIT.
REQ-016 SHALL, in WAIT, on rd_busy sampled low, write rd_data to the FIFO on that edge, add 4 to the address and decrement the remaining count.
REQ-017 SHALL, after that write, go to ISSUE if words remain and the FIFO has space, otherwise to DONE.
REQ-018 SHALL, in DONE, go to IDLE after one cycle.
REQ-019 SHALL allow only one read outstanding at any time.
REQ-020 SHALL increment the address modulo 2^ADDR_W (0xFFFFFC+4 = 0x000000).
REQ-021 SHALL provide a FIFO with 33-bit entries ({last, data}), where last=1 only on the final word of a burst.
REQ-022 SHALL drive out_valid = FIFO not empty, assert out_last with the final word, and pop the FIFO on out_valid && out_ready.
REQ-023 SHALL give a latency of 1 cycle from accepted req_start to rd_start high, and assert out_valid on the cycle after the WAIT capture edge.
REQ-024 SHALL handle a simultaneous FIFO push and pop with the count unchanged, including the full-with-pop case.
REQ-025 SHALL hold out_data stable while out_valid && !out_ready.

Reset
REQ-026 SHALL, on rst high, immediately set: state IDLE, rd_start 0, rd_addr 0, FIFO empty, out_valid 0, out_last 0, out_data 0, remaining count 0.
REQ-027 SHALL, after a reset taken mid-read, keep req_ready low until rd_busy is low, and discard that in-flight word.

Configuration
REQ-028 SHALL, when W25Q_STREAM_BYTESWAP_EN is defined, write byte-reversed rd_data into the FIFO (0x11223344 becomes 0x44332211); when it is undefined, rd_data passes unmodified.

Structure
REQ-029 SHALL place the FSM state encoding, the address step constant (4) and the default FIFO_DEPTH in the shared package w25q_pkg.
REQ-030 SHALL implement the buffer as the sub-module w25q_word_fifo (synchronous, parameterised width/depth, async reset, with full, empty and count outputs).

Verification
REQ-031 SHALL verify a single-word burst: addr=0x010000, words=1, reader returns 0xFFFFFFFF -> one rd_start with rd_addr=0x010000, then out_data=0xFFFFFFFF with out_last=1.
REQ-032 SHALL verify backpressure: words=6 with out_ready=0 -> exactly 4 reads (0x010000..0x01000C) then rd_start stays low; raising out_ready -> reads at 0x010010 and 0x010014 follow, and out_last is on word 6 only.
REQ-033 SHALL verify address wrap: addr=0xFFFFF8, words=3 -> rd_addr sequence 0xFFFFF8, 0xFFFFFC, 0x000000.
REQ-034 SHALL verify a zero-length request: words=0 -> no rd_start, req_ready stays 1, out_valid stays 0.
REQ-035 SHALL verify reset in WAIT: outputs clear in the same cycle, req_ready stays 0 until the model drops rd_busy, and no word is output.
REQ-036 SHALL verify byte swap: rd_data=0x11223344 -> out_data=0x44332211 with W25Q_STREAM_BYTESWAP_EN defined, and 0x11223344 without it.
